// File: rtl/issue_pkg.sv
// Shared definitions for the issue queue and the control unit: opcodes,
// instruction field layout and the decode helpers.
package issue_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;

  localparam int OPC_LSB = 13;
  localparam int RD_LSB  = 10;
  localparam int RS1_LSB = 7;
  localparam int RS2_LSB = 4;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [3:0] rsvd;
  } instr_t;

  // Issue history entry; a bubble is all-zero, so wr=0
  typedef struct packed {
    logic       wr;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
  } hist_t;

  // ALU ops both write rd and read rs1/rs2; everything else does neither
  function automatic logic writes_rd(input logic [2:0] opcode);
    logic w;
    case (opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: w = 1'b1;
      OP_NOP:                        w = 1'b0;
      default:                       w = 1'b0;
    endcase
    return w;
  endfunction

  function automatic instr_t decode(input logic [15:0] word);
    instr_t d;
    d.opcode = word[OPC_LSB +: 3];
    d.rd     = word[RD_LSB +: 3];
    d.rs1    = word[RS1_LSB +: 3];
    d.rs2    = word[RS2_LSB +: 3];
    d.rsvd   = word[3:0];
    return d;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; head word is readable
// combinationally while the FIFO is non-empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push_s, do_pop_s;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;
  assign rdata     = mem_q[rd_ptr_q];
  assign count     = count_q;

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_issue_queue.sv
// Instruction issue queue: buffers fetched words, issues one per cycle and
// inserts bubbles on RAW hazards against the last two issued instructions.
module instr_issue_queue
  import issue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  input  logic          stall,
  input  logic          flush,
  output logic          out_valid,
  output logic [2:0]    out_opcode,
  output logic [2:0]    out_rd_d1,
  output logic [2:0]    out_rs1_d1,
  output logic [2:0]    out_rs2_d1,
  output logic [CW-1:0] count,
  output logic [15:0]   bubble_cnt
);

  logic        fifo_full_s, fifo_empty_s, push_s, pop_s, hazard_s, unused_rsvd_s;
  logic [15:0] fifo_rdata_s;
  instr_t      head_s;
  hist_t       h0_q, h0_d, h1_q, h1_d;
  logic        valid_q, valid_d;
  logic [2:0]  opcode_q, opcode_d;
  logic [15:0] bubble_q, bubble_d;

  function automatic logic raw_hit(input hist_t h, input logic [2:0] rs1, input logic [2:0] rs2);
    return h.wr & (h.rd != 3'd0) & ((h.rd == rs1) | (h.rd == rs2));
  endfunction

  // A full FIFO refuses pushes even when a pop happens in the same cycle
  assign in_ready = rst_n & ~flush & ~fifo_full_s;
  assign push_s   = in_valid & in_ready;

  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (in_instr),
    .rdata (fifo_rdata_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (count)
  );

  assign head_s        = decode(fifo_rdata_s);
  assign unused_rsvd_s = ^head_s.rsvd;
  assign hazard_s      = writes_rd(head_s.opcode) &
                         (raw_hit(h0_q, head_s.rs1, head_s.rs2) |
                          raw_hit(h1_q, head_s.rs1, head_s.rs2));

  // Issue decision in priority order: flush, stall, empty, hazard, issue
  always_comb begin
    valid_d  = 1'b0;
    opcode_d = OP_NOP;
    h0_d     = '0;
    h1_d     = h0_q;
    pop_s    = 1'b0;
    bubble_d = bubble_q;
    if (flush) begin
      h1_d = '0;
    end else if (stall || fifo_empty_s) begin
      h0_d = '0;
    end else if (hazard_s) begin
      bubble_d = (bubble_q == 16'hFFFF) ? bubble_q : bubble_q + 16'd1;
    end else begin
      valid_d  = 1'b1;
      opcode_d = head_s.opcode;
      pop_s    = 1'b1;
      h0_d     = '{wr: writes_rd(head_s.opcode), rd: head_s.rd, rs1: head_s.rs1, rs2: head_s.rs2};
    end
  end

  // Issue register, history pipeline and bubble counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      opcode_q <= OP_NOP;
      h0_q     <= '0;
      h1_q     <= '0;
      bubble_q <= 16'd0;
    end else begin
      valid_q  <= valid_d;
      opcode_q <= opcode_d;
      h0_q     <= h0_d;
      h1_q     <= h1_d;
      bubble_q <= bubble_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_opcode = opcode_q;
  assign out_rd_d1  = h1_q.rd;
  assign out_rs1_d1 = h1_q.rs1;
  assign out_rs2_d1 = h1_q.rs2;
  assign bubble_cnt = bubble_q;

endmodule
